alu_seq: RTL and testbench

Parametrised, sequential successor to the combinational execute-stage ALU. It accepts one operation at a time over a valid/ready handshake. Base integer ops complete in one cycle. Unsigned multiply and divide run iteratively over XLEN cycles. The result is held registered until the downstream stage takes it. It sits between decode/register-read and writeback, and lets the core stall cleanly on long-latency ops.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_muldiv.sv | 76 +++++++
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states, op classification.
package alu_pkg;

  localparam int OPW_DEF = 5;

  typedef enum logic [OPW_DEF-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_XOR   = 5'd2,
    OP_OR    = 5'd3,
    OP_AND   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_MUL   = 5'd10,
    OP_MULHU = 5'd11,
    OP_DIVU  = 5'd12,
    OP_REMU  = 5'd13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [31:0] op);
    return (op == 32'(OP_MUL))  || (op == 32'(OP_MULHU)) ||
           (op == 32'(OP_DIVU)) || (op == 32'(OP_REMU));
  endfunction

  function automatic logic is_divide(input logic [31:0] op);
    return (op == 32'(OP_DIVU)) || (op == 32'(OP_REMU));
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle, XLEN cycles.
// done pulses combinationally on the final iteration; lo/hi then carry that iteration's result.
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            div_q, div_d;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;

  // hi/lo hold product-high/multiplier for MUL and remainder/dividend-quotient for DIV.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    div_d    = div_q;
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (start) begin
      cnt_d = CW'(XLEN);
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      div_d = is_div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (div_q) begin
        hi_d = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign done = (cnt_q == CW'(1));
  assign lo   = lo_d;
  assign hi   = hi_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle base ops, XLEN-cycle mul/div; result registered until out_ready.
// Accepts only in IDLE; holds result in DONE until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] v1,
  input  logic [XLEN-1:0] v2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res, md_res, md_lo, md_hi;
  logic [SHW-1:0]  shamt;
  logic            accept, iter_op, md_start, md_is_div, md_done;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign iter_op   = is_iterative(32'(op));
  assign md_is_div = is_divide(32'(op));
  assign md_start  = accept && iter_op;
  assign shamt     = v2[SHW-1:0];

  alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (md_is_div),
    .a      (v1),
    .b      (v2),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OPW'(OP_ADD):  alu_res = v1 + v2;
      OPW'(OP_SUB):  alu_res = v1 - v2;
      OPW'(OP_XOR):  alu_res = v1 ^ v2;
      OPW'(OP_OR):   alu_res = v1 | v2;
      OPW'(OP_AND):  alu_res = v1 & v2;
      OPW'(OP_SLL):  alu_res = v1 << shamt;
      OPW'(OP_SRL):  alu_res = v1 >> shamt;
      OPW'(OP_SRA):  alu_res = $unsigned($signed(v1) >>> shamt);
      OPW'(OP_SLT):  alu_res = {{(XLEN-1){1'b0}}, $signed(v1) < $signed(v2)};
      OPW'(OP_SLTU): alu_res = {{(XLEN-1){1'b0}}, v1 < v2};
      default:       alu_res = '0;
    endcase
  end

  // Quotient and product-low land in lo, remainder and product-high in hi.
  always_comb begin
    md_res = md_lo;
    if ((op_q == OPW'(OP_MULHU)) || (op_q == OPW'(OP_REMU))) begin
      md_res = md_hi;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = iter_op ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    result_d = result_q;
    if (accept) begin
      op_d = op;
      if (!iter_op) result_d = alu_res;
    end else if ((state_q == ST_BUSY) && md_done) begin
      result_d = md_res;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_BUSY);
    out_valid = (state_q == ST_DONE);
    result    = result_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int OPW  = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [OPW-1:0]  op = '0;
  logic [XLEN-1:0] v1 = '0;
  logic [XLEN-1:0] v2 = '0;
  logic            in_ready, out_valid, busy;
  logic [XLEN-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .v1        (v1),
    .v2        (v2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dv [17] = '{
    '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000},
    '{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF},
    '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001},
    '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
    '{OP_SRA,   32'h80000000, 32'h00000004, 32'hF8000000},
    '{OP_SRL,   32'h80000000, 32'h00000004, 32'h08000000},
    '{OP_SLL,   32'h00000003, 32'h00000021, 32'h00000006},
    '{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
    '{OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0},
    '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
    '{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{OP_DIVU,  32'd100,      32'd7,        32'd14},
    '{OP_REMU,  32'd100,      32'd7,        32'd2},
    '{OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF},
    '{OP_REMU,  32'd5,        32'd0,        32'd5},
    '{5'd31,    32'h00000001, 32'h00000001, 32'h00000000}
  };

  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sh;
    sh = int'(b & 32'd31);
    p  = {32'd0, a} * {32'd0, b};
    case (o)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_XOR:   return a ^ b;
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_SLL:   return a << sh;
      OP_SRL:   return a >> sh;
      OP_SRA:   return $unsigned($signed(a) >>> sh);
      OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic bit is_long(input logic [4:0] o);
    return (o == OP_MUL) || (o == OP_MULHU) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  // Offers one op, scrambles inputs after accept, returns result, latency and busy-cycle count.
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit early_rdy, output logic [31:0] res, output int lat, output int bcnt);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1; op = o; v1 = a; v2 = b; out_ready = early_rdy;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); v1 = $urandom; v2 = $urandom;
    lat = 0; bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end while (!out_valid && lat < 100);
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
    vectors++;
    if (result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %h want 00000000", result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, bcnt;
    for (int i = 0; i < 17; i++) begin
      do_op(dv[i].o, dv[i].a, dv[i].b, bit'(i % 2), res, lat, bcnt);
      vectors++;
      if (res !== dv[i].e) begin
        miscompares++;
        $display("FAIL directed[%0d] op=%0d: got %h want %h", i, dv[i].o, res, dv[i].e);
      end
      vectors++;
      if (lat !== (is_long(dv[i].o) ? 33 : 1)) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, is_long(dv[i].o) ? 33 : 1);
      end
      vectors++;
      if (bcnt !== (is_long(dv[i].o) ? 32 : 0)) begin
        miscompares++;
        $display("FAIL directed_busy[%0d]: got %0d want %0d", i, bcnt, is_long(dv[i].o) ? 32 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, sp [5];
    logic [4:0] o;
    int lat, bcnt;
    sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 40; i++) begin
      o = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 13)) : 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      if ((o == OP_DIVU || o == OP_REMU) && $urandom_range(0, 1) == 1) b = b >> $urandom_range(8, 31);
      do_op(o, a, b, bit'($urandom_range(0, 1)), res, lat, bcnt);
      vectors++;
      if (res !== ref_alu(o, a, b) || lat !== (is_long(o) ? 33 : 1)) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 i, o, a, b, res, lat, ref_alu(o, a, b), is_long(o) ? 33 : 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp, held;
    int n, bcnt, stray;
    exp = ref_alu(OP_MUL, 32'd123457, 32'd98765);
    @(negedge clk);
    in_valid = 1'b1; op = OP_MUL; v1 = 32'd123457; v2 = 32'd98765; out_ready = 1'b0;
    @(posedge clk); #1;
    op = OP_ADD; v1 = 32'd1; v2 = 32'd1;
    n = 0; bcnt = 0; stray = 0;
    do begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (busy) bcnt++;
      if (in_ready) stray++;
    end while (!out_valid && n < 100);
    held = result;
    vectors++;
    if (held !== exp || bcnt !== 32) begin
      miscompares++;
      $display("FAIL bp_mul: got %h busy %0d want %h busy 32", held, bcnt, exp);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready || !out_valid) stray++;
      vectors++;
      if (result !== held) begin
        miscompares++;
        $display("FAIL bp_stable[%0d]: got %h want %h", k, result, held);
      end
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL bp_no_accept: got %0d cycles with in_ready/out_valid wrong want 0", stray);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_after: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bcnt, seen;
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVU; v1 = 32'hDEADBEEF; v2 = 32'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset: got flags %b result %h want 100 00000000", {in_ready, out_valid, busy}, result);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    out_ready = 1'b0;
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midreset_stray: got %0d cycles with out_valid/busy want 0", seen);
    end
    do_op(OP_ADD, 32'd2, 32'd3, 1'b0, res, lat, bcnt);
    vectors++;
    if (res !== 32'd5 || lat !== 1) begin
      miscompares++;
      $display("FAIL midreset_add: got %h lat %0d want 00000005 lat 1", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] exp;
    logic [4:0] o;
    int n_out, n_in;
    n_out = 0; n_in = 0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        n_out++;
        exp = (q.size() != 0) ? q.pop_front() : ~result;
        vectors++;
        if (result !== exp) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got %h want %h", i, result, exp);
        end
      end
      if (in_ready) begin
        o = 5'($urandom_range(0, 9));
        op = o; v1 = $urandom; v2 = $urandom;
        q.push_back(ref_alu(o, v1, v2));
        n_in++;
      end
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (n_out !== 10 || n_in !== 10) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0d in %0d out want 10 in 10 out", n_in, n_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
